branch_resolve_pipe: RTL and testbench

//  Multi-port, registered successor of the single-port branch unit. Resolves up to NR_PORTS

---
 rtl/branch_resolve_pipe.sv | 180 ++++++++++++++++++
 tb/tb_branch_resolve_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe
//   Registered multi-port branch resolution. Up to NR_PORTS control-flow
//   instructions are resolved per cycle, with port 0 the oldest. Each port
//   produces a link value, a resolved target, a mispredict flag and a
//   misaligned-target exception. The oldest terminating event (mispredict
//   or exception) wins. Younger ports are squashed. A mispredict winner
//   raises a single frontend redirect. After any winner, all resolutions
//   are locked out until flush_i arrives.
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i            commit-side flush; clears outputs and releases lockout
//   valid_i, kind_i    per-port instruction valid / kind (00 BR, 01 JAL, 10 JALR, 11 JAL)
//   pc_i, operand_a_i, imm_i, compressed_i, comp_res_i   per-port operands
//   pred_cf_i, pred_addr_i                               per-port prediction
//   res_*_o, link_o    per-port resolution (registered)
//   ex_valid_o, ex_tval_o  per-port INSTR_ADDR_MISALIGNED
//   redirect_valid_o, redirect_pc_o  single frontend redirect pulse
//   locked_o           lockout state
module branch_resolve_pipe #(
    parameter int unsigned VLEN     = 64,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NR_PORTS = 2,
    parameter bit          RVC      = 1'b1,
    parameter bit          TVAL_EN  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NR_PORTS-1:0]      valid_i,
    input  logic [2*NR_PORTS-1:0]    kind_i,
    input  logic [VLEN*NR_PORTS-1:0] pc_i,
    input  logic [VLEN*NR_PORTS-1:0] operand_a_i,
    input  logic [VLEN*NR_PORTS-1:0] imm_i,
    input  logic [NR_PORTS-1:0]      compressed_i,
    input  logic [NR_PORTS-1:0]      comp_res_i,
    input  logic [3*NR_PORTS-1:0]    pred_cf_i,
    input  logic [VLEN*NR_PORTS-1:0] pred_addr_i,
    output logic [NR_PORTS-1:0]      res_valid_o,
    output logic [VLEN*NR_PORTS-1:0] res_target_o,
    output logic [NR_PORTS-1:0]      res_taken_o,
    output logic [NR_PORTS-1:0]      res_mispredict_o,
    output logic [3*NR_PORTS-1:0]    res_cf_o,
    output logic [VLEN*NR_PORTS-1:0] link_o,
    output logic [NR_PORTS-1:0]      ex_valid_o,
    output logic [XLEN*NR_PORTS-1:0] ex_tval_o,
    output logic                     redirect_valid_o,
    output logic [VLEN-1:0]          redirect_pc_o,
    output logic                     locked_o
);

    typedef enum logic {RUN, LOCK} state_e;
    typedef enum logic [2:0] {CF_NOCF, CF_BRANCH, CF_JUMP, CF_JUMPR, CF_RETURN} cf_e;

    state_e state_q;

    logic [NR_PORTS-1:0]      valid_d, valid_q;
    logic [VLEN*NR_PORTS-1:0] target_d, target_q;
    logic [NR_PORTS-1:0]      taken_d, taken_q;
    logic [NR_PORTS-1:0]      mis_d, mis_q;
    logic [3*NR_PORTS-1:0]    cf_d, cf_q;
    logic [VLEN*NR_PORTS-1:0] link_d, link_q;
    logic [NR_PORTS-1:0]      exv_d, exv_q;
    logic [XLEN*NR_PORTS-1:0] tval_d, tval_q;
    logic                     redir_v_d, redir_v_q;
    logic [VLEN-1:0]          redir_pc_d, redir_pc_q;
    logic                     winner;

    // per-port scratch, fully rewritten on every loop iteration
    logic [VLEN-1:0] pc_c, nxt_c, tgt_c, res_c;
    logic [2:0]      pcf_c, cf_c;
    logic            is_br_c, is_jalr_c, taken_c, ex_c, mis_raw_c, mis_c, live_c;

    always_comb begin
        valid_d    = '0;
        target_d   = '0;
        taken_d    = '0;
        mis_d      = '0;
        cf_d       = '0;
        link_d     = '0;
        exv_d      = '0;
        tval_d     = '0;
        redir_v_d  = 1'b0;
        redir_pc_d = '0;
        winner     = 1'b0;
        pc_c = '0; nxt_c = '0; tgt_c = '0; res_c = '0; pcf_c = '0; cf_c = '0;
        is_br_c = 1'b0; is_jalr_c = 1'b0; taken_c = 1'b0; ex_c = 1'b0;
        mis_raw_c = 1'b0; mis_c = 1'b0; live_c = 1'b0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            pc_c      = pc_i[p*VLEN +: VLEN];
            pcf_c     = pred_cf_i[3*p +: 3];
            is_br_c   = (kind_i[2*p +: 2] == 2'b00);
            is_jalr_c = (kind_i[2*p +: 2] == 2'b10);
            nxt_c     = pc_c + (compressed_i[p] ? VLEN'(2) : VLEN'(4));
            tgt_c     = (is_jalr_c ? operand_a_i[p*VLEN +: VLEN] : pc_c) + imm_i[p*VLEN +: VLEN];
            if (is_jalr_c) tgt_c[0] = 1'b0;
            taken_c   = is_br_c ? comp_res_i[p] : 1'b1;
            res_c     = taken_c ? tgt_c : nxt_c;
            // with RVC only bit 0 matters; otherwise 4-byte alignment is required
            ex_c      = taken_c & (tgt_c[0] | (~RVC & tgt_c[1]));
            if (is_br_c)        mis_raw_c = (taken_c != (pcf_c == CF_BRANCH));
            else if (is_jalr_c) mis_raw_c = (pcf_c == CF_NOCF) || (tgt_c != pred_addr_i[p*VLEN +: VLEN]);
            else                mis_raw_c = 1'b0;
            if (is_br_c)                                         cf_c = CF_BRANCH;
            else if (is_jalr_c && mis_raw_c && pcf_c != CF_RETURN) cf_c = CF_JUMPR;
            else                                                 cf_c = pcf_c;
            mis_c     = mis_raw_c & ~ex_c;
            // ports younger than the first terminating event are squashed
            live_c    = valid_i[p] & ~winner;
            if (live_c) begin
                valid_d[p]               = 1'b1;
                target_d[p*VLEN +: VLEN] = res_c;
                taken_d[p]               = taken_c;
                mis_d[p]                 = mis_c;
                cf_d[3*p +: 3]           = cf_c;
                link_d[p*VLEN +: VLEN]   = nxt_c;
                exv_d[p]                 = ex_c;
                if (ex_c && TVAL_EN) tval_d[p*XLEN +: XLEN] = XLEN'($signed(pc_c));
                if (mis_c || ex_c) begin
                    winner = 1'b1;
                    if (mis_c) begin
                        redir_v_d  = 1'b1;
                        redir_pc_d = res_c;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            state_q    <= RUN;
            valid_q    <= '0;
            target_q   <= '0;
            taken_q    <= '0;
            mis_q      <= '0;
            cf_q       <= '0;
            link_q     <= '0;
            exv_q      <= '0;
            tval_q     <= '0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else if (state_q == LOCK) begin
            valid_q    <= '0;
            target_q   <= '0;
            taken_q    <= '0;
            mis_q      <= '0;
            cf_q       <= '0;
            link_q     <= '0;
            exv_q      <= '0;
            tval_q     <= '0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            valid_q    <= valid_d;
            target_q   <= target_d;
            taken_q    <= taken_d;
            mis_q      <= mis_d;
            cf_q       <= cf_d;
            link_q     <= link_d;
            exv_q      <= exv_d;
            tval_q     <= tval_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            if (winner) state_q <= LOCK;
        end
    end

    assign res_valid_o      = valid_q;
    assign res_target_o     = target_q;
    assign res_taken_o      = taken_q;
    assign res_mispredict_o = mis_q;
    assign res_cf_o         = cf_q;
    assign link_o           = link_q;
    assign ex_valid_o       = exv_q;
    assign ex_tval_o        = tval_q;
    assign redirect_valid_o = redir_v_q;
    assign redirect_pc_o    = redir_pc_q;
    assign locked_o         = (state_q == LOCK);

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// tb_branch_resolve_pipe
//   Drives one RVC=1 and one RVC=0 instance with identical stimulus.
//   Expected responses come from a rule-level reference model and are
//   queued per instance; a monitor pops and compares one entry per cycle.
module tb_branch_resolve_pipe;

    localparam int VL = 64;
    localparam int NP = 2;

    typedef struct packed {
        logic [1:0]       rv, taken, mis, exv;
        logic [1:0][63:0] tgt, link, tval;
        logic [1:0][2:0]  cf;
        logic             redv;
        logic [63:0]      redpc;
        logic             locked;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, flush;
    logic [NP-1:0]   valid, comp, cmp;
    logic [2*NP-1:0] kind;
    logic [3*NP-1:0] pcf;
    logic [VL*NP-1:0] pc, opa, imm, paddr;

    logic [NP-1:0] a_rv, a_tk, a_mis, a_exv, b_rv, b_tk, b_mis, b_exv;
    logic [VL*NP-1:0] a_tgt, a_link, a_tval, b_tgt, b_link, b_tval;
    logic [3*NP-1:0] a_cf, b_cf;
    logic a_redv, a_lk, b_redv, b_lk;
    logic [VL-1:0] a_redpc, b_redpc;

    branch_resolve_pipe #(.VLEN(64), .XLEN(64), .NR_PORTS(2), .RVC(1'b1), .TVAL_EN(1'b1)) u_rvc1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .kind_i(kind),
        .pc_i(pc), .operand_a_i(opa), .imm_i(imm), .compressed_i(comp), .comp_res_i(cmp),
        .pred_cf_i(pcf), .pred_addr_i(paddr),
        .res_valid_o(a_rv), .res_target_o(a_tgt), .res_taken_o(a_tk), .res_mispredict_o(a_mis),
        .res_cf_o(a_cf), .link_o(a_link), .ex_valid_o(a_exv), .ex_tval_o(a_tval),
        .redirect_valid_o(a_redv), .redirect_pc_o(a_redpc), .locked_o(a_lk));

    branch_resolve_pipe #(.VLEN(64), .XLEN(64), .NR_PORTS(2), .RVC(1'b0), .TVAL_EN(1'b1)) u_rvc0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .kind_i(kind),
        .pc_i(pc), .operand_a_i(opa), .imm_i(imm), .compressed_i(comp), .comp_res_i(cmp),
        .pred_cf_i(pcf), .pred_addr_i(paddr),
        .res_valid_o(b_rv), .res_target_o(b_tgt), .res_taken_o(b_tk), .res_mispredict_o(b_mis),
        .res_cf_o(b_cf), .link_o(b_link), .ex_valid_o(b_exv), .ex_tval_o(b_tval),
        .redirect_valid_o(b_redv), .redirect_pc_o(b_redpc), .locked_o(b_lk));

    exp_t qa[$];
    exp_t qb[$];
    bit   lock_a, lock_b;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model: rules applied to the current inputs; lk is the lockout flag.
    function automatic exp_t model(bit rvc, inout bit lk);
        exp_t e;
        bit found;
        logic [63:0] p_pc, nx, tg;
        logic [1:0] k;
        logic [2:0] pc_cf, cfv;
        bit tk, x, m;
        e = '0;
        found = 0;
        if (!rst_n || flush) begin
            lk = 0;
        end else if (!lk) begin
            for (int p = 0; p < NP; p++) begin
                p_pc  = pc[p*64 +: 64];
                k     = kind[2*p +: 2];
                pc_cf = pcf[3*p +: 3];
                nx    = p_pc + (comp[p] ? 64'd2 : 64'd4);
                tg    = ((k == 2) ? opa[p*64 +: 64] : p_pc) + imm[p*64 +: 64];
                if (k == 2) tg = tg - (tg % 2);
                tk    = (k == 0) ? cmp[p] : 1'b1;
                x     = tk && ((tg % 2) == 1 || (!rvc && ((tg / 2) % 2) == 1));
                if (k == 0)      m = (tk != (pc_cf == 1));
                else if (k == 2) m = (pc_cf == 0) || (tg != paddr[p*64 +: 64]);
                else             m = 0;
                if (k == 0)           cfv = 3'd1;
                else if (k == 2 && m) cfv = (pc_cf == 4) ? 3'd4 : 3'd3;
                else                  cfv = pc_cf;
                m = m && !x;
                if (valid[p] && !found) begin
                    e.rv[p]    = 1;
                    e.tgt[p]   = tk ? tg : nx;
                    e.taken[p] = tk;
                    e.mis[p]   = m;
                    e.cf[p]    = cfv;
                    e.link[p]  = nx;
                    e.exv[p]   = x;
                    e.tval[p]  = x ? p_pc : 64'd0;
                    if (m || x) begin
                        found = 1;
                        if (m) begin
                            e.redv  = 1;
                            e.redpc = tk ? tg : nx;
                        end
                    end
                end
            end
            if (found) lk = 1;
        end
        e.locked = lk;
        return e;
    endfunction

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", what, cyc, act, expv);
        end
    endtask

    task automatic check_dut(input string nm, input exp_t e,
                             input logic [1:0] rv, tk, mis, exv,
                             input logic [127:0] tgt, link, tval,
                             input logic [5:0] cf,
                             input logic redv, input logic [63:0] redpc, input logic lk);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s p%0d res_valid", nm, p), 64'(rv[p]), 64'(e.rv[p]));
            chk($sformatf("%s p%0d ex_valid", nm, p), 64'(exv[p]), 64'(e.exv[p]));
            chk($sformatf("%s p%0d mispredict", nm, p), 64'(mis[p]), 64'(e.mis[p]));
            if (e.rv[p]) begin
                chk($sformatf("%s p%0d target", nm, p), tgt[p*64 +: 64], e.tgt[p]);
                chk($sformatf("%s p%0d taken", nm, p), 64'(tk[p]), 64'(e.taken[p]));
                chk($sformatf("%s p%0d cf", nm, p), 64'(cf[3*p +: 3]), 64'(e.cf[p]));
                chk($sformatf("%s p%0d link", nm, p), link[p*64 +: 64], e.link[p]);
                chk($sformatf("%s p%0d tval", nm, p), tval[p*64 +: 64], e.tval[p]);
            end
        end
        chk($sformatf("%s redirect_valid", nm), 64'(redv), 64'(e.redv));
        if (e.redv) chk($sformatf("%s redirect_pc", nm), redpc, e.redpc);
        chk($sformatf("%s locked", nm), 64'(lk), 64'(e.locked));
    endtask

    // Monitor: outputs of the previous edge are stable 2 time units after it.
    always @(posedge clk) begin
        exp_t ea, eb;
        #2;
        cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            check_dut("rvc1", ea, a_rv, a_tk, a_mis, a_exv, a_tgt, a_link, a_tval, a_cf, a_redv, a_redpc, a_lk);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            check_dut("rvc0", eb, b_rv, b_tk, b_mis, b_exv, b_tgt, b_link, b_tval, b_cf, b_redv, b_redpc, b_lk);
        end
    end

    task automatic clr();
        valid = '0; kind = '0; pc = '0; opa = '0; imm = '0;
        comp = '0; cmp = '0; pcf = '0; paddr = '0;
    endtask

    task automatic setp(input int p, input bit v, input logic [1:0] k, input logic [63:0] ppc,
                        input logic [63:0] a, input logic [63:0] im, input bit c, input bit r,
                        input logic [2:0] pc_cf, input logic [63:0] pa);
        valid[p] = v; kind[2*p +: 2] = k; pc[p*64 +: 64] = ppc; opa[p*64 +: 64] = a;
        imm[p*64 +: 64] = im; comp[p] = c; cmp[p] = r; pcf[3*p +: 3] = pc_cf;
        paddr[p*64 +: 64] = pa;
    endtask

    // Inputs are applied 3 units after the edge, after the monitor has sampled.
    task automatic issue();
        qa.push_back(model(1'b1, lock_a));
        qb.push_back(model(1'b0, lock_b));
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic [63:0] rpc, ra, ri;
        lock_a = 0; lock_b = 0;
        rst_n = 1'b0; flush = 1'b0; clr();
        @(posedge clk); #3;
        repeat (3) issue();
        rst_n = 1'b1;

        // taken branch predicted NoCF
        setp(0, 1, 2'b00, 64'h1000, 64'h0, 64'h20, 0, 1, 3'd0, 64'h0); issue();
        clr(); issue();
        flush = 1'b1; issue(); flush = 1'b0;
        // compressed JALR, correctly predicted
        setp(0, 1, 2'b10, 64'h3000, 64'h2003, 64'h0, 1, 0, 3'd3, 64'h2002); issue();
        clr(); issue();
        // BNE mispredict on port 0 squashes JAL on port 1; held inputs ignored
        setp(0, 1, 2'b00, 64'h4000, 64'h0, 64'h40, 0, 0, 3'd1, 64'h0);
        setp(1, 1, 2'b01, 64'h4004, 64'h0, 64'h100, 0, 0, 3'd2, 64'h0); issue();
        repeat (2) issue();
        clr(); flush = 1'b1; issue(); flush = 1'b0;
        // JAL to 0x106 on port 1: misaligned only without RVC
        setp(1, 1, 2'b01, 64'h100, 64'h0, 64'h6, 0, 0, 3'd2, 64'h0); issue();
        clr(); issue();
        flush = 1'b1; issue(); flush = 1'b0;
        // flush together with valid in LOCK, then a normal resolution
        setp(0, 1, 2'b00, 64'h1000, 64'h0, 64'h20, 0, 1, 3'd0, 64'h0); issue();
        flush = 1'b1; issue(); flush = 1'b0;
        issue();
        clr(); flush = 1'b1; issue(); flush = 1'b0;
        // reset during LOCK with res_valid high, then pc wrap
        setp(0, 1, 2'b00, 64'h1000, 64'h0, 64'h20, 0, 1, 3'd0, 64'h0); issue();
        clr(); setp(0, 1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h4, 0, 0, 3'd2, 64'h0);
        rst_n = 1'b0; issue();
        rst_n = 1'b1; issue();
        clr(); flush = 1'b1; issue(); flush = 1'b0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            clr();
            for (int p = 0; p < NP; p++) begin
                rpc = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 7) * 2)
                                                  : {32'h0, $urandom} & ~64'h1;
                ra  = {$urandom, $urandom};
                ri  = 64'($signed(32'($urandom_range(0, 1023)) - 32'sd512));
                if ($urandom_range(0, 7) != 0) ri = ri & ~64'h1;
                setp(p, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rpc, ra, ri,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
                     $urandom_range(0, 1) ? ((ra + ri) & ~64'h1) : {$urandom, $urandom});
            end
            flush = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            issue();
        end
        clr(); flush = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
        #3;
        checks++;
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d expected=0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
